// File: rtl/soc_cpu_2_nios2_oci_dct_packer_if.sv
// Symbol, frame and status bundle for the data-trace packer.
// The master side presents symbols and accepts frames; the slave side is the packer.
interface soc_cpu_2_nios2_oci_dct_packer_if;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic        flush;
    logic        test_ending;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        frame_ready;
    logic [7:0]  drop_count;
    logic        test_has_ended;

    modport master (
        output sym_valid, sym_data, flush, test_ending, frame_ready,
        input  sym_ready, dct_buffer, dct_count, frame_valid, frame_data,
               frame_count, drop_count, test_has_ended
    );

    modport slave (
        input  sym_valid, sym_data, flush, test_ending, frame_ready,
        output sym_ready, dct_buffer, dct_count, frame_valid, frame_data,
               frame_count, drop_count, test_has_ended
    );
endinterface

// File: rtl/soc_cpu_2_nios2_oci_dct_packer.sv
// Data-trace packer: gathers 2-bit trace symbols into 15-slot, 30-bit frames,
// emits partial frames on flush or end-of-test, and counts dropped symbols.
module soc_cpu_2_nios2_oci_dct_packer (
    input  logic clk,
    input  logic reset,
    soc_cpu_2_nios2_oci_dct_packer_if.slave bus
);
    typedef enum logic [1:0] {FILL, FULL_WAIT, DRAIN, ENDED} state_t;

    state_t      state_q, state_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fv_q, fv_d;
    logic [29:0] fd_q, fd_d;
    logic [3:0]  fc_q, fc_d;
    logic [7:0]  drop_q, drop_d;
    logic        ended_q, ended_d;

    logic        orf;
    logic        accept;
    logic [29:0] buf_acc;
    logic [3:0]  cnt_acc;
    logic        load;
    logic [29:0] load_data;
    logic [3:0]  load_count;

    // Next-state logic: symbol insertion, frame transfer, drop counting and FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        fv_d       = fv_q;
        fd_d       = fd_q;
        fc_d       = fc_q;
        drop_d     = drop_q;
        ended_d    = ended_q;
        load       = 1'b0;
        load_data  = buf_q;
        load_count = cnt_q;

        // The output register is free when empty or being taken this cycle.
        orf    = !fv_q || bus.frame_ready;
        accept = bus.sym_valid && (state_q == FILL);

        // Buffer and count as they look after this cycle's accepted symbol.
        buf_acc = buf_q;
        cnt_acc = cnt_q;
        if (accept) begin
            buf_acc = buf_q | ({28'b0, bus.sym_data} << {cnt_q, 1'b0});
            cnt_acc = cnt_q + 4'd1;
        end

        if (bus.sym_valid && !accept && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;

        case (state_q)
            FILL: begin
                if (accept && (cnt_q == 4'd14)) begin
                    // A full word wins over any flush in the same cycle.
                    if (orf) begin
                        load       = 1'b1;
                        load_data  = buf_acc;
                        load_count = 4'd15;
                    end else begin
                        buf_d   = buf_acc;
                        cnt_d   = 4'd15;
                        state_d = FULL_WAIT;
                    end
                end else begin
                    buf_d = buf_acc;
                    cnt_d = cnt_acc;
                    if ((bus.flush || bus.test_ending) && (cnt_acc != 4'd0)) begin
                        state_d = DRAIN;
                    end else if (bus.test_ending && !fv_q) begin
                        state_d = ENDED;
                        ended_d = 1'b1;
                    end
                end
            end
            FULL_WAIT: begin
                if (orf) begin
                    load       = 1'b1;
                    load_data  = buf_q;
                    load_count = 4'd15;
                    state_d    = FILL;
                end
            end
            DRAIN: begin
                if (orf) begin
                    load       = 1'b1;
                    load_data  = buf_q;
                    load_count = cnt_q;
                    state_d    = FILL;
                end
            end
            default: ;
        endcase

        // Frame register: a load replaces it, otherwise a handshake empties it.
        if (load) begin
            fv_d  = 1'b1;
            fd_d  = load_data;
            fc_d  = load_count;
            buf_d = '0;
            cnt_d = '0;
        end else if (fv_q && bus.frame_ready) begin
            fv_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            fd_q    <= '0;
            fc_q    <= '0;
            drop_q  <= '0;
            ended_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            fd_q    <= fd_d;
            fc_q    <= fc_d;
            drop_q  <= drop_d;
            ended_q <= ended_d;
        end
    end

    assign bus.sym_ready      = (state_q == FILL);
    assign bus.dct_buffer     = buf_q;
    assign bus.dct_count      = cnt_q;
    assign bus.frame_valid    = fv_q;
    assign bus.frame_data     = fd_q;
    assign bus.frame_count    = fc_q;
    assign bus.drop_count     = drop_q;
    assign bus.test_has_ended = ended_q;
endmodule

// File: tb/tb_soc_cpu_2_nios2_oci_dct_packer.sv
// Directed bench for the data-trace packer.
module tb_soc_cpu_2_nios2_oci_dct_packer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    soc_cpu_2_nios2_oci_dct_packer_if bus ();

    soc_cpu_2_nios2_oci_dct_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sym_valid   = 1'b0;
        bus.sym_data    = 2'b00;
        bus.flush       = 1'b0;
        bus.test_ending = 1'b0;
        bus.frame_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_syms(input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_data  = d;
            tick();
        end
        bus.sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.dct_count !== 4'd0 || bus.dct_buffer !== 30'd0 || bus.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cnt=%0d buf=%h fv=%b required 0/0/0", bus.dct_count, bus.dct_buffer, bus.frame_valid);
        end
        checks++;
        if (bus.sym_ready !== 1'b1 || bus.drop_count !== 8'd0 || bus.test_has_ended !== 1'b0) begin
            failures++;
            $display("FAIL reset_status rdy=%b drop=%0d end=%b required 1/0/0", bus.sym_ready, bus.drop_count, bus.test_has_ended);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        send_syms(2'b01, 15);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 30'h15555555 || bus.frame_count !== 4'd15 || bus.dct_count !== 4'd0) begin
            failures++;
            $display("FAIL full_frame fv=%b data=%h fc=%0d cnt=%0d required 1/15555555/15/0",
                     bus.frame_valid, bus.frame_data, bus.frame_count, bus.dct_count);
        end
        tick();
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_frame_drop fv=%b required 0", bus.frame_valid);
        end
    endtask

    task automatic test_flush_partial();
        do_reset();
        send_syms(2'b11, 1);
        send_syms(2'b10, 1);
        send_syms(2'b01, 1);
        checks++;
        if (bus.dct_buffer !== 30'h0000001B || bus.dct_count !== 4'd3) begin
            failures++;
            $display("FAIL partial_buffer buf=%h cnt=%0d required 0000001b/3", bus.dct_buffer, bus.dct_count);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 30'h0000001B || bus.frame_count !== 4'd3 || bus.dct_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_frame fv=%b data=%h fc=%0d cnt=%0d required 1/0000001b/3/0",
                     bus.frame_valid, bus.frame_data, bus.frame_count, bus.dct_count);
        end
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL empty_flush fv=%b rdy=%b required 0/1", bus.frame_valid, bus.sym_ready);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.frame_ready = 1'b0;
        send_syms(2'b01, 15);
        for (int i = 0; i < 30; i++) begin
            bus.sym_valid = 1'b1;
            bus.sym_data  = 2'b10;
            tick();
            if (i == 20) begin
                checks++;
                if (bus.frame_data !== 30'h15555555 || bus.frame_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL held_frame_mid data=%h fv=%b required 15555555/1", bus.frame_data, bus.frame_valid);
                end
            end
        end
        bus.sym_valid = 1'b0;
        checks++;
        if (bus.frame_data !== 30'h15555555 || bus.frame_count !== 4'd15 || bus.frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL held_frame data=%h fc=%0d fv=%b required 15555555/15/1", bus.frame_data, bus.frame_count, bus.frame_valid);
        end
        checks++;
        if (bus.dct_count !== 4'd15 || bus.dct_buffer !== 30'h2AAAAAAA || bus.sym_ready !== 1'b0 || bus.drop_count !== 8'd15) begin
            failures++;
            $display("FAIL full_wait cnt=%0d buf=%h rdy=%b drop=%0d required 15/2aaaaaaa/0/15",
                     bus.dct_count, bus.dct_buffer, bus.sym_ready, bus.drop_count);
        end
        bus.frame_ready = 1'b1;
        tick();
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 30'h2AAAAAAA || bus.frame_count !== 4'd15 ||
            bus.dct_count !== 4'd0 || bus.sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_wait_release fv=%b data=%h fc=%0d cnt=%0d rdy=%b required 1/2aaaaaaa/15/0/1",
                     bus.frame_valid, bus.frame_data, bus.frame_count, bus.dct_count, bus.sym_ready);
        end
    endtask

    task automatic test_flush_with_full();
        int extra;
        do_reset();
        send_syms(2'b11, 14);
        bus.flush = 1'b1;
        send_syms(2'b10, 1);
        bus.flush = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 30'h2FFFFFFF || bus.frame_count !== 4'd15 || bus.dct_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_and_full fv=%b data=%h fc=%0d cnt=%0d required 1/2fffffff/15/0",
                     bus.frame_valid, bus.frame_data, bus.frame_count, bus.dct_count);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.frame_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL no_empty_frame extra_valid_cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_test_ending();
        do_reset();
        bus.frame_ready = 1'b0;
        send_syms(2'b01, 5);
        bus.test_ending = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame_count !== 4'd5 || bus.frame_data !== 30'h00000155 || bus.test_has_ended !== 1'b0) begin
            failures++;
            $display("FAIL drain_frame fv=%b fc=%0d data=%h end=%b required 1/5/00000155/0",
                     bus.frame_valid, bus.frame_count, bus.frame_data, bus.test_has_ended);
        end
        bus.frame_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.test_has_ended !== 1'b1 || bus.sym_ready !== 1'b0 || bus.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL ended end=%b rdy=%b fv=%b required 1/0/0", bus.test_has_ended, bus.sym_ready, bus.frame_valid);
        end
        send_syms(2'b11, 2);
        checks++;
        if (bus.test_has_ended !== 1'b1 || bus.sym_ready !== 1'b0 || bus.drop_count !== 8'd2 || bus.dct_count !== 4'd0) begin
            failures++;
            $display("FAIL ended_sticky end=%b rdy=%b drop=%0d cnt=%0d required 1/0/2/0",
                     bus.test_has_ended, bus.sym_ready, bus.drop_count, bus.dct_count);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        bus.frame_ready = 1'b0;
        send_syms(2'b01, 24);
        checks++;
        if (bus.dct_count !== 4'd9 || bus.frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL midframe_setup cnt=%0d fv=%b required 9/1", bus.dct_count, bus.frame_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.dct_count !== 4'd0 || bus.dct_buffer !== 30'd0 || bus.frame_valid !== 1'b0 ||
            bus.frame_data !== 30'd0 || bus.frame_count !== 4'd0 || bus.drop_count !== 8'd0 || bus.test_has_ended !== 1'b0) begin
            failures++;
            $display("FAIL async_reset cnt=%0d buf=%h fv=%b data=%h fc=%0d drop=%0d end=%b required all 0",
                     bus.dct_count, bus.dct_buffer, bus.frame_valid, bus.frame_data, bus.frame_count,
                     bus.drop_count, bus.test_has_ended);
        end
        tick();
        reset = 1'b0;
        send_syms(2'b11, 1);
        checks++;
        if (bus.dct_count !== 4'd1 || bus.dct_buffer !== 30'h00000003) begin
            failures++;
            $display("FAIL first_accept cnt=%0d buf=%h required 1/00000003", bus.dct_count, bus.dct_buffer);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_full_frame();
        test_flush_partial();
        test_backpressure();
        test_flush_with_full();
        test_test_ending();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/soc_cpu_2_nios2_oci_dct_packer.md
SOC_CPU_2_NIOS2_OCI_DCT_PACKER -- requirements
Module: soc_cpu_2_nios2_oci_dct_packer

Interface
REQ-001 The block SHALL have one clock, clk, and reset, an asynchronous, active-high reset named reset.
REQ-002 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high; clears all state.
REQ-004 Port sym_valid, input, 1 bit: a compressed data-trace symbol is presented.
REQ-005 Port sym_data, input, 2 bits: trace symbol.
REQ-006 Port sym_ready, output, 1 bit: the packer accepts a symbol this cycle.
REQ-007 Port flush, input, 1 bit: single-cycle request to emit the partial frame.
REQ-008 Port test_ending, input, 1 bit: level; end-of-test drain request.
REQ-009 Port dct_buffer, output, 30 bits: live packing buffer; slot k occupies bits [2k+1:2k].
REQ-010 Port dct_count, output, 4 bits: number of valid slots in dct_buffer, 0..15.
REQ-011 Port frame_valid, output, 1 bit; frame_data, output, 30 bits; frame_count, output, 4 bits: downstream frame.
REQ-012 Port frame_ready, input, 1 bit: downstream accepts the frame.
REQ-013 Port drop_count, output, 8 bits: saturating count of dropped symbols.
REQ-014 Port test_has_ended, output, 1 bit: sticky; the drain is complete.

Function
REQ-015 The states SHALL be FILL, FULL_WAIT, DRAIN and ENDED; reset enters FILL.
REQ-016 Output-register free (ORF) SHALL be defined as !frame_valid || frame_ready.
REQ-017 sym_ready SHALL equal (state==FILL); a symbol is accepted when sym_valid && sym_ready.
REQ-018 An accepted symbol SHALL be written to slot dct_count, and dct_count SHALL increment in the same cycle.
REQ-019 When the 15th symbol is accepted (dct_count==14) and ORF holds, the full 30-bit word SHALL load frame_data with frame_count=15 and frame_valid=1 on the next edge, and dct_buffer/dct_count SHALL clear to 0.
REQ-020 If ORF is false on the 15th accept, the buffer SHALL hold with dct_count=15 and the state SHALL move to FULL_WAIT.
REQ-021 In FULL_WAIT, the transfer of REQ-019 SHALL occur on the first cycle ORF holds, and the state SHALL return to FILL.
REQ-022 flush in FILL with dct_count>0 (after including any symbol accepted in the same cycle) SHALL enter DRAIN; flush with dct_count==0 SHALL be ignored.
REQ-023 DRAIN SHALL transfer the partial frame on the first ORF cycle (frame_count=dct_count, unused slots 0), clear the buffer and return to FILL.
REQ-024 A simultaneous flush and 15th symbol SHALL produce exactly one 15-slot frame.
REQ-025 While frame_valid=1 and frame_ready=0, frame_data/frame_count SHALL remain stable; frame_valid SHALL drop after a handshake with no new load.
REQ-026 Each cycle with sym_valid=1 and sym_ready=0 SHALL increment drop_count, saturating at 255.
REQ-027 test_ending=1 in FILL or FULL_WAIT SHALL complete any pending transfer and drain a partial frame as in DRAIN, then enter ENDED once frame_valid=0 and dct_count=0.
REQ-028 ENDED SHALL assert test_has_ended=1 and hold sym_ready=0 until reset.

Reset
REQ-029 Reset SHALL force dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, drop_count=0 and test_has_ended=0, and the state SHALL return to FILL, including mid-frame or mid-drain.
REQ-030 The first symbol SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-031 15 symbols of 2'b01 with frame_ready=1 -> frame_valid=1, frame_data=30'h15555555, frame_count=15, dct_count=0.
REQ-032 3 symbols 2'b11, 2'b10, 2'b01, then flush -> frame_data=30'h0000001B, frame_count=3.
REQ-033 frame_ready=0 with 30 symbols offered -> first frame held stable, FULL_WAIT with dct_count=15, sym_ready=0, drop_count=15.
REQ-034 Flush and the 15th symbol in the same cycle -> exactly one frame with frame_count=15 and no empty frame.
REQ-035 5 symbols, then test_ending=1, then frame_ready=1 -> a frame with frame_count=5, then test_has_ended=1 and sym_ready=0.
REQ-036 Reset asserted with dct_count=9 and frame_valid=1 -> all outputs 0 immediately.
